gate_bist: RTL

Built-in self-test engine for the two-input basic gates (nand_gate, and_gate and siblings). It is the driving end of the gate interface:
- It applies the four input vectors {a,b} = 00, 01, 10, 11 in order.
- It waits a programmable settle time after each vector, then samples the gate output y.
- It compares each sample against a 4-bit expected truth table and reports pass/fail with a per-vector mismatch mask.

It replaces hand-written vector sequences in benches and can sit on-chip next to any gate instance.

---
 rtl/gate_bist_pkg.sv | 21 ++
 rtl/gate_bist_settle_cnt.sv | 33 +++
 rtl/gate_bist.sv | 112 +++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate self-test engine.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  // Truth tables indexed by {a,b}: bit 0 is a=0,b=0.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Loadable 4-bit down-counter timing how long each vector is held.
module gate_bist_settle_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_bist.sv
// Self-test engine: walks {a,b} through 00..11, samples y after a settle
// time and compares it with a captured expected truth table.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [3:0] exp_tt_q;
  logic [3:0] fail_mask_q;
  logic [3:0] fail_mask_d;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic       cnt_zero, accept, sample, cnt_load, cnt_dec;

  // The single DONE cycle also serves as the earliest point a new start is
  // taken, so a held start yields runs spaced by exactly one idle cycle.
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign sample   = (state_q == SETTLE) && cnt_zero;
  assign cnt_load = accept || (sample && (idx_q != LAST_IDX));
  assign cnt_dec  = (state_q == SETTLE) && !cnt_zero;

  always_comb begin
    fail_mask_d        = fail_mask_q;
    fail_mask_d[idx_q] = fail_mask_q[idx_q] | (y != exp_tt_q[idx_q]);
  end

  gate_bist_settle_cnt u_settle_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (RELOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      exp_tt_q <= exp_tt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q     <= SETTLE;
            idx_q       <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (sample) begin
            fail_mask_q <= fail_mask_d;
            if (idx_q != LAST_IDX) begin
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end else begin
              state_q    <= DONE;
              idx_q      <= 2'd0;
              {a_q, b_q} <= 2'b00;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (fail_mask_d == 4'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule
